// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side control bundle for pipeline_ctrl: hazard sources from ID/EX/MEM,
// per-stage enable/flush controls, and the data-memory request/acknowledge pair.
interface pipeline_ctrl_if;
    logic [4:0] ID_R1idx;
    logic [4:0] ID_R2idx;
    logic       ID_R1used;
    logic       ID_R2used;
    logic [4:0] EX_rdidx;
    logic       EX_MemRead;
    logic       EX_br_taken;
    logic       MEM_MemRead;
    logic       MEM_MemWrite;
    logic       dmem_ack;

    logic       PC_en;
    logic       IF_ID_en;
    logic       ID_EX_en;
    logic       EX_MEM_en;
    logic       MEM_WB_en;
    logic       IF_ID_flush;
    logic       ID_EX_flush;
    logic       MEM_WB_flush;
    logic       dmem_req;

    // Controller side: consumes hazard info and ack, drives stage controls and req.
    modport master (
        input  ID_R1idx, ID_R2idx, ID_R1used, ID_R2used,
        input  EX_rdidx, EX_MemRead, EX_br_taken,
        input  MEM_MemRead, MEM_MemWrite, dmem_ack,
        output PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
        output IF_ID_flush, ID_EX_flush, MEM_WB_flush, dmem_req
    );

    // Datapath / memory side.
    modport slave (
        output ID_R1idx, ID_R2idx, ID_R1used, ID_R2used,
        output EX_rdidx, EX_MemRead, EX_br_taken,
        output MEM_MemRead, MEM_MemWrite, dmem_ack,
        input  PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
        input  IF_ID_flush, ID_EX_flush, MEM_WB_flush, dmem_req
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, branch redirect
// flushes, whole-pipeline freeze while a data-memory access waits for its ack.
module pipeline_ctrl #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 64
) (
    input  logic             clk,
    input  logic             rstn,
    pipeline_ctrl_if.master  bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_MAX[WAIT_W-1:0];
    localparam logic [WAIT_W-1:0] WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              memop_s;
    logic              freeze_s;
    logic              load_use_s;
    logic              pc_en_s;
    logic              if_id_en_s;
    logic              id_ex_en_s;
    logic              ex_mem_en_s;
    logic              mem_wb_en_s;
    logic              if_id_flush_s;
    logic              id_ex_flush_s;
    logic              mem_wb_flush_s;
    logic              dmem_req_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic              mem_err_r;

    // A source operand hazards only if the instruction really reads that register.
    function automatic logic src_hit(input logic used, input logic [4:0] src,
                                     input logic [4:0] dst);
        return used & (src == dst);
    endfunction

    assign memop_s    = bus.MEM_MemRead | bus.MEM_MemWrite;
    assign load_use_s = bus.EX_MemRead & (bus.EX_rdidx != 5'd0) &
                        (src_hit(bus.ID_R1used, bus.ID_R1idx, bus.EX_rdidx) |
                         src_hit(bus.ID_R2used, bus.ID_R2idx, bus.EX_rdidx));

    // Next state and freeze decision from the memory handshake.
    always_comb begin
        state_next_s = state_r;
        freeze_s     = 1'b0;
        case (state_r)
            RUN: begin
                if (memop_s && !bus.dmem_ack) begin
                    state_next_s = MEM_WAIT;
                    freeze_s     = 1'b1;
                end else begin
                    state_next_s = RUN;
                    freeze_s     = 1'b0;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ack) begin
                    state_next_s = RUN;
                    freeze_s     = 1'b0;
                end else begin
                    state_next_s = MEM_WAIT;
                    freeze_s     = 1'b1;
                end
            end
            default: begin
                state_next_s = RUN;
                freeze_s     = 1'b0;
            end
        endcase
    end

    // Stage enables/flushes: freeze beats redirect, redirect beats load-use.
    always_comb begin
        pc_en_s        = 1'b1;
        if_id_en_s     = 1'b1;
        id_ex_en_s     = 1'b1;
        ex_mem_en_s    = 1'b1;
        mem_wb_en_s    = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        mem_wb_flush_s = 1'b0;
        if (freeze_s) begin
            pc_en_s        = 1'b0;
            if_id_en_s     = 1'b0;
            id_ex_en_s     = 1'b0;
            ex_mem_en_s    = 1'b0;
            mem_wb_en_s    = 1'b0;
            mem_wb_flush_s = 1'b1;
        end else if (bus.EX_br_taken) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
        end else if (load_use_s) begin
            pc_en_s       = 1'b0;
            if_id_en_s    = 1'b0;
            id_ex_flush_s = 1'b1;
        end else begin
            if_id_flush_s = 1'b0;
        end
    end

    // Request stays up for the whole wait, regardless of MEM inputs.
    always_comb begin
        dmem_req_s = 1'b0;
        if (state_r == MEM_WAIT) begin
            dmem_req_s = 1'b1;
        end else begin
            dmem_req_s = memop_s;
        end
    end

    assign bus.PC_en        = pc_en_s;
    assign bus.IF_ID_en     = if_id_en_s;
    assign bus.ID_EX_en     = id_ex_en_s;
    assign bus.EX_MEM_en    = ex_mem_en_s;
    assign bus.MEM_WB_en    = mem_wb_en_s;
    assign bus.IF_ID_flush  = if_id_flush_s;
    assign bus.ID_EX_flush  = id_ex_flush_s;
    assign bus.MEM_WB_flush = mem_wb_flush_s;
    assign bus.dmem_req     = dmem_req_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Wait-cycle counter (counts freeze cycles of one access) and sticky timeout flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
            mem_err_r  <= 1'b0;
        end else begin
            if (freeze_s && (state_r == RUN)) begin
                wait_cnt_r <= WAIT_ONE;
                if (WAIT_ONE == WAIT_MAX_C) begin
                    mem_err_r <= 1'b1;
                end
            end else if (freeze_s && (wait_cnt_r != WAIT_MAX_C)) begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                if ((wait_cnt_r + WAIT_ONE) == WAIT_MAX_C) begin
                    mem_err_r <= 1'b1;
                end
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Performance counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (!pc_en_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (!freeze_s && bus.EX_br_taken) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
    assign mem_err   = mem_err_r;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (WAIT_MAX shortened to 4).
module tb_pipeline_ctrl;
    logic        clk;
    logic        rstn;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic        mem_err;
    int          checks;
    int          errors;

    pipeline_ctrl_if bus();

    pipeline_ctrl #(.CNT_W(32), .WAIT_MAX(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .mem_err   (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB} enables and {IF_ID, ID_EX, MEM_WB} flushes
    function automatic logic [31:0] en_vec();
        return 32'({bus.PC_en, bus.IF_ID_en, bus.ID_EX_en, bus.EX_MEM_en, bus.MEM_WB_en});
    endfunction

    function automatic logic [31:0] fl_vec();
        return 32'({bus.IF_ID_flush, bus.ID_EX_flush, bus.MEM_WB_flush});
    endfunction

    task automatic clear_inputs();
        bus.ID_R1idx     = 5'd0;
        bus.ID_R2idx     = 5'd0;
        bus.ID_R1used    = 1'b0;
        bus.ID_R2used    = 1'b0;
        bus.EX_rdidx     = 5'd0;
        bus.EX_MemRead   = 1'b0;
        bus.EX_br_taken  = 1'b0;
        bus.MEM_MemRead  = 1'b0;
        bus.MEM_MemWrite = 1'b0;
        bus.dmem_ack     = 1'b0;
    endtask

    // Inputs are applied 1 time unit after posedge; comb outputs checked on negedge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb(input string tag, input logic [31:0] en,
                              input logic [31:0] fl, input logic [31:0] req);
        @(negedge clk);
        check_val({tag, "_en"}, en_vec(), en);
        check_val({tag, "_fl"}, fl_vec(), fl);
        check_val({tag, "_req"}, 32'(bus.dmem_req), req);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        clear_inputs();

        repeat (2) @(posedge clk);
        check_comb("reset", 32'h1F, 32'h0, 32'h0);
        check_val("reset_stall", stall_cnt, 32'd0);
        check_val("reset_flush", flush_cnt, 32'd0);
        check_val("reset_err", 32'(mem_err), 32'd0);
        next_cycle();
        rstn = 1'b1;
        next_cycle();

        // Load-use through R2
        bus.EX_MemRead = 1'b1; bus.EX_rdidx = 5'd5;
        bus.ID_R1used = 1'b1; bus.ID_R1idx = 5'd3;
        bus.ID_R2used = 1'b1; bus.ID_R2idx = 5'd5;
        check_comb("lu", 32'h07, 32'h2, 32'h0);
        next_cycle();
        check_val("lu_stall", stall_cnt, 32'd1);

        // Same but destination x0: no hazard
        bus.EX_rdidx = 5'd0; bus.ID_R2idx = 5'd0;
        check_comb("lu_x0", 32'h1F, 32'h0, 32'h0);
        next_cycle();
        check_val("lu_x0_stall", stall_cnt, 32'd1);

        // R1 matches but is not used: no hazard
        bus.EX_rdidx = 5'd7; bus.ID_R1idx = 5'd7; bus.ID_R1used = 1'b0;
        bus.ID_R2idx = 5'd2;
        check_comb("lu_unused", 32'h1F, 32'h0, 32'h0);
        next_cycle();

        // Redirect with a simultaneous load-use
        bus.ID_R1used = 1'b1; bus.EX_br_taken = 1'b1;
        check_comb("br_lu", 32'h1F, 32'h6, 32'h0);
        next_cycle();
        check_val("br_lu_flushcnt", flush_cnt, 32'd1);
        check_val("br_lu_stall", stall_cnt, 32'd1);
        clear_inputs();

        // Load, ack 3 cycles after first request
        bus.MEM_MemRead = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_comb("wait3_frz", 32'h00, 32'h1, 32'h1);
            next_cycle();
        end
        bus.dmem_ack = 1'b1;
        check_comb("wait3_ack", 32'h1F, 32'h0, 32'h1);
        next_cycle();
        clear_inputs();
        check_val("wait3_stall", stall_cnt, 32'd4);
        check_comb("wait3_run", 32'h1F, 32'h0, 32'h0);
        check_val("wait3_err", 32'(mem_err), 32'd0);
        next_cycle();

        // Zero-wait store
        bus.MEM_MemWrite = 1'b1; bus.dmem_ack = 1'b1;
        check_comb("zw", 32'h1F, 32'h0, 32'h1);
        next_cycle();
        clear_inputs();
        check_val("zw_stall", stall_cnt, 32'd4);

        // Taken branch held in EX during a 2-cycle wait
        bus.MEM_MemRead = 1'b1; bus.EX_br_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_comb("wbr_frz", 32'h00, 32'h1, 32'h1);
            next_cycle();
        end
        check_val("wbr_flushcnt_hold", flush_cnt, 32'd1);
        bus.dmem_ack = 1'b1;
        check_comb("wbr_ack", 32'h1F, 32'h6, 32'h1);
        next_cycle();
        clear_inputs();
        check_val("wbr_flushcnt", flush_cnt, 32'd2);
        check_val("wbr_stall", stall_cnt, 32'd6);

        // Stray ack without request is ignored
        bus.dmem_ack = 1'b1;
        check_comb("stray_ack", 32'h1F, 32'h0, 32'h0);
        next_cycle();
        clear_inputs();

        // Timeout: no ack for 6 cycles, err after the 4th wait cycle
        bus.MEM_MemRead = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            check_comb("to_frz", 32'h00, 32'h1, 32'h1);
            next_cycle();
            check_val("to_err", 32'(mem_err), (k >= 4) ? 32'd1 : 32'd0);
        end
        bus.dmem_ack = 1'b1;
        check_comb("to_ack", 32'h1F, 32'h0, 32'h1);
        next_cycle();
        clear_inputs();
        check_val("to_err_sticky", 32'(mem_err), 32'd1);
        check_val("to_stall", stall_cnt, 32'd12);

        // Async reset in the middle of a wait
        bus.MEM_MemRead = 1'b1;
        next_cycle();
        next_cycle();
        bus.MEM_MemRead = 1'b0;
        #1;
        check_val("mid_req_held", 32'(bus.dmem_req), 32'd1);
        rstn = 1'b0;
        #1;
        check_val("mid_rst_req", 32'(bus.dmem_req), 32'd0);
        check_val("mid_rst_en", en_vec(), 32'h1F);
        check_val("mid_rst_err", 32'(mem_err), 32'd0);
        check_val("mid_rst_stall", stall_cnt, 32'd0);
        check_val("mid_rst_flush", flush_cnt, 32'd0);
        next_cycle();
        rstn = 1'b1;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
